// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave with NUM_REGS 32-bit read/write registers, exported flat on regs_out.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axil_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  r_aw_held;
    logic                  r_w_held;
    logic [IDX_W-1:0]      r_awidx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_aw_have;
    logic                  w_w_have;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]         w_wr_strb;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_wr_resp;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign w_aw_hs   = AWVALID && r_awready;
    assign w_w_hs    = WVALID && r_wready;
    assign w_ar_hs   = ARVALID && r_arready;
    assign w_aw_have = r_aw_held || w_aw_hs;
    assign w_w_have  = r_w_held || w_w_hs;
    assign w_commit  = (r_wstate == W_COLLECT) && w_aw_have && w_w_have;

    // A half that handshakes on the commit edge is taken straight from the bus.
    assign w_wr_idx  = r_aw_held ? r_awidx : AWADDR[ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_held ? r_wdata : WDATA;
    assign w_wr_strb = r_w_held ? r_wstrb : WSTRB;
    assign w_rd_idx  = ARADDR[ADDR_WIDTH-1:2];

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W+1)'(NUM_REGS);
    logic w_wr_inrange;
    logic w_rd_inrange;
    assign w_wr_inrange = {1'b0, w_wr_idx} < LP_NUM_REGS;
    assign w_rd_inrange = {1'b0, w_rd_idx} < LP_NUM_REGS;
    assign w_wr_resp    = w_wr_inrange ? 2'b00 : 2'b11;
    assign w_rd_resp    = w_rd_inrange ? 2'b00 : 2'b11;
`else
    assign w_wr_resp = 2'b00;
    assign w_rd_resp = 2'b00;
`endif

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if ({{(32-IDX_W){1'b0}}, w_rd_idx} == i)
                w_rd_data = r_regs[i];
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            regs_out[DATA_WIDTH*i +: DATA_WIDTH] = r_regs[i];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if ({{(32-IDX_W){1'b0}}, w_wr_idx} == i) begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (w_wr_strb[b])
                            r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_COLLECT;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_COLLECT: begin
                    if (w_aw_hs) begin
                        r_awidx   <= AWADDR[ADDR_WIDTH-1:2];
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= WDATA;
                        r_wstrb  <= WSTRB;
                        r_w_held <= 1'b1;
                    end
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_resp;
                        r_wstate  <= W_RESP;
                    end else begin
                        r_awready <= !w_aw_have;
                        r_wready  <= !w_w_have;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = r_rdata;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile: a vector table of AXI-Lite accesses plus
// hand sequences for split AW/W, back-pressure, same-edge write/read and mid-transaction reset.
module tb_axil_slave_regfile;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [4:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [4:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] regs_out;

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0] OOR_RESP = 2'b11;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    axil_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_out(regs_out)
    );

    always #5 ACLK = ~ACLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned b_hs_cnt = 0;
    logic [31:0] model [4];

    always @(posedge ACLK) if (BVALID && BREADY) b_hs_cnt++;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[4:2] < 3'd4)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a[4:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        logic aw_done, w_done, aw_now, w_now;
        int unsigned n;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; ok = 1'b0; resp = 2'b00; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            tick();
            if (aw_now) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_now)  begin WVALID  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        if (BVALID && aw_done && w_done) begin
            ok = 1'b1;
            resp = BRESP;
            BREADY = 1'b1;
            tick();
            BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        logic ar_now, ar_done;
        int unsigned n;
        ARADDR = a; ARVALID = 1'b1; ar_done = 1'b0; ok = 1'b0; data = '0; resp = 2'b00; n = 0;
        while (!ar_done && n < 20) begin
            ar_now = ARVALID && ARREADY;
            tick();
            if (ar_now) begin ARVALID = 1'b0; ar_done = 1'b1; end
            n++;
        end
        ARVALID = 1'b0;
        if (ar_done) begin
            check("rd_latency_rvalid", RVALID, 1'b1);
            n = 0;
            while (!RVALID && n < 20) begin tick(); n++; end
            if (RVALID) begin
                ok = 1'b1;
                data = RDATA;
                resp = RRESP;
                RREADY = 1'b1;
                tick();
                RREADY = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        bit          ok;
        int unsigned b0;

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        tick();
        tick();
        check("reset_ready_valid", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
        check("reset_resp_rdata", {BRESP, RRESP, RDATA}, 36'h0);
        check("reset_regs", regs_out, 128'h0);
        ARESET = 1'b0;
        tick();
        check("post_reset_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

        vecs.push_back('{1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00});
        vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_0002, 2'b00});
        vecs.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00});
        vecs.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0004, 2'b00});
        vecs.push_back('{1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1'b1, 5'h04, 32'h0000_0000, 4'b0101, 32'h0, 2'b00});
        vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'hFF00_FF00, 2'b00});
        vecs.push_back('{1'b1, 5'h08, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00});
        vecs.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00});
        vecs.push_back('{1'b0, 5'h0E, 32'h0, 4'h0, 32'h0000_0004, 2'b00});
        vecs.push_back('{1'b1, 5'h10, 32'h0000_DEAD, 4'hF, 32'h0, OOR_RESP});
        vecs.push_back('{1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0000, OOR_RESP});
        vecs.push_back('{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0000_0000, OOR_RESP});
        vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00});
        vecs.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0004, 2'b00});

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, rs, ok);
                check($sformatf("v%0d_wr_done", k), ok, 1'b1);
                check($sformatf("v%0d_bresp", k), rs, vecs[k].exp_resp);
                model_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
                check($sformatf("v%0d_regs_out", k), regs_out, model_flat());
            end else begin
                axi_read(vecs[k].addr, rd, rs, ok);
                check($sformatf("v%0d_rd_done", k), ok, 1'b1);
                check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
                check($sformatf("v%0d_rresp", k), rs, vecs[k].exp_resp);
            end
        end

        // W leads AW by three cycles
        b0 = b_hs_cnt;
        WDATA = 32'h0000_00A5; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("wfirst_wready_low", {WREADY, AWREADY}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wfirst_no_bvalid_%0d", i), BVALID, 1'b0);
            tick();
        end
        AWADDR = 5'h08; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("wfirst_bvalid", {BVALID, BRESP}, 3'b100);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        tick();
        check("wfirst_one_bpulse", b_hs_cnt - b0, 1);
        model_write(5'h08, 32'h0000_00A5, 4'hF);
        check("wfirst_regs_out", regs_out, model_flat());

        // AW leads W by three cycles
        b0 = b_hs_cnt;
        AWADDR = 5'h04; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("awfirst_awready_low", {AWREADY, WREADY}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("awfirst_no_bvalid_%0d", i), BVALID, 1'b0);
            tick();
        end
        WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("awfirst_bvalid", {BVALID, BRESP}, 3'b100);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        tick();
        check("awfirst_one_bpulse", b_hs_cnt - b0, 1);
        axi_read(5'h04, rd, rs, ok);
        check("awfirst_readback", {ok, rd}, {1'b1, 32'h1234_5678});
        axi_read(5'h08, rd, rs, ok);
        check("wfirst_readback", {ok, rd}, {1'b1, 32'h0000_00A5});

        // back-pressure on B and R
        AWADDR = 5'h00; WDATA = 32'hCAFE_0001; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bstall_%0d", i), {BVALID, BRESP, AWREADY, WREADY}, 5'b1_00_0_0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        model_write(5'h00, 32'hCAFE_0001, 4'hF);
        ARADDR = 5'h00; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rstall_%0d", i), {RVALID, RRESP, ARREADY, RDATA}, {4'b1_00_0, 32'hCAFE_0001});
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("rstall_release", {RVALID, BVALID}, 2'b00);

        // write commit and read of the same register on one edge
        check("sameedge_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        AWADDR = 5'h00; WDATA = 32'h1111_1111; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 5'h00; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("sameedge_old_value", {BVALID, RVALID, RDATA}, {2'b11, 32'hCAFE_0001});
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        model_write(5'h00, 32'h1111_1111, 4'hF);
        axi_read(5'h00, rd, rs, ok);
        check("sameedge_new_value", {ok, rd}, {1'b1, 32'h1111_1111});

        // reset with a write response and a read response pending
        AWADDR = 5'h0C; WDATA = 32'h0000_0077; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 5'h04; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        check("pre_reset_pending", {BVALID, RVALID}, 2'b11);
        ARESET = 1'b1;
        tick();
        check("midreset_ready_valid", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
        check("midreset_regs", regs_out, 128'h0);
        check("midreset_rdata", RDATA, 32'h0);
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        tick();
        axi_write(5'h08, 32'h0000_0005, 4'hF, rs, ok);
        check("postreset_wr", {ok, rs}, 3'b100);
        model_write(5'h08, 32'h0000_0005, 4'hF);
        check("postreset_regs_out", regs_out, model_flat());
        axi_read(5'h08, rd, rs, ok);
        check("postreset_rd", {ok, rs, rd}, {3'b100, 32'h0000_0005});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
